// File: rtl/fft_res_reader.sv
// Streams one FFT result frame over valid/ready, through a 4-deep FIFO.
// Define FFT_MAG_OUT_EN to add the |re|+|im| out_mag port.
module fft_res_reader #(
  parameter int N_POINTS = 128,
  parameter int ADDR_W   = 7,
  parameter int DW       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fft_done,
  output logic [ADDR_W-1:0] res_addr,
  output logic              res_rd,
  input  logic [2*DW-1:0]   fft_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_re,
  output logic [DW-1:0]     out_im,
  output logic [ADDR_W-1:0] out_bin,
  output logic              out_last,
`ifdef FFT_MAG_OUT_EN
  output logic [DW:0]       out_mag,
`endif
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(N_POINTS - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic              have_rd;
  logic              rd_q;
  logic [2:0]        count;
  logic [1:0]        wptr;
  logic [1:0]        rptr;
  logic              start;
  logic              push;
  logic              pop;
  logic              last_rd;
  logic              last_pop;

  logic [DW-1:0] re_mem [4];
  logic [DW-1:0] im_mem [4];

  assign start = fft_done && (state == IDLE);
  assign busy  = (state != IDLE);

  // Credits cover both stored entries and the read still in flight.
  assign res_rd = (state == READ) &&
                  ((count + {2'b0, rd_q}) < 3'd4);

  // addr_q holds the last issued address so a stall parks on it.
  assign res_addr = (res_rd && have_rd) ?
                    addr_q + ADDR_W'(1) : addr_q;

  assign last_rd   = res_rd && (res_addr == LAST);
  assign push      = rd_q;
  assign out_valid = (count != 3'd0);
  assign pop       = out_valid && out_ready;
  assign last_pop  = pop && (out_bin == LAST);
  assign out_last  = out_valid && (out_bin == LAST);
  assign out_re    = re_mem[rptr];
  assign out_im    = im_mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= last_pop;
      if (fft_done && state != IDLE)
        overrun <= 1'b1;
      unique case (1'b1)
        (state == IDLE):  if (fft_done) state <= READ;
        (state == READ):  if (last_rd) state <= DRAIN;
        (state == DRAIN): if (last_pop) state <= IDLE;
        default:          state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      have_rd <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      rd_q <= res_rd;
      if (start) begin
        addr_q  <= '0;
        have_rd <= 1'b0;
      end else if (res_rd) begin
        addr_q  <= res_addr;
        have_rd <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 3'd0;
      wptr    <= 2'd0;
      rptr    <= 2'd0;
      out_bin <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (push) wptr <= wptr + 2'd1;
      if (pop) begin
        rptr    <= rptr + 2'd1;
        out_bin <= out_bin + ADDR_W'(1);
      end else if (start) begin
        out_bin <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        re_mem[i] <= '0;
        im_mem[i] <= '0;
      end
    end else if (push) begin
      re_mem[wptr] <= fft_res[2*DW-1:DW];
      im_mem[wptr] <= fft_res[DW-1:0];
    end
  end

`ifdef FFT_MAG_OUT_EN
  logic [DW:0] mag_mem [4];
  logic [DW:0] mag_in;

  function automatic logic [DW:0] abs_ext(
    input logic [DW-1:0] v
  );
    logic [DW:0] s;
    s = {v[DW-1], v};
    return v[DW-1] ? -s : s;
  endfunction

  // One extra bit keeps |-2**(DW-1)| exact.
  assign mag_in = abs_ext(fft_res[2*DW-1:DW]) +
                  abs_ext(fft_res[DW-1:0]);
  assign out_mag = mag_mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)
        mag_mem[i] <= '0;
    end else if (push) begin
      mag_mem[wptr] <= mag_in;
    end
  end
`endif

endmodule

// File: tb/tb_fft_res_reader.sv
// Directed bench for fft_res_reader with a 1-cycle result RAM model.
// Magnitude checks run only when FFT_MAG_OUT_EN is defined.
module tb_fft_res_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fft_done;
  logic [6:0] res_addr;
  logic       res_rd;
  logic [15:0] fft_res;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_re;
  logic [7:0] out_im;
  logic [6:0] out_bin;
  logic       out_last;
`ifdef FFT_MAG_OUT_EN
  logic [8:0] out_mag;
`endif
  logic       busy;
  logic       frame_done;
  logic       overrun;

  logic [7:0] ram_re [128];
  logic [7:0] ram_im [128];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_res_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fft_done   (fft_done),
    .res_addr   (res_addr),
    .res_rd     (res_rd),
    .fft_res    (fft_res),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_bin    (out_bin),
    .out_last   (out_last),
`ifdef FFT_MAG_OUT_EN
    .out_mag    (out_mag),
`endif
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always @(posedge clk)
    if (res_rd)
      fft_res <= {ram_re[res_addr], ram_im[res_addr]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Runs the rest of a frame, tracking beats and read credits.
  task automatic stream(input string tag, input bit rnd,
                        input int inject, input int issued0);
    int  exp     = 0;
    int  issued  = issued0;
    int  acc     = 0;
    int  bad     = 0;
    int  credbad = 0;
    int  cyc     = 0;
    bit  done    = 0;
    bit  injd    = 0;
    while (!done && cyc < 3000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      fft_done  = 1'b0;
      if (inject >= 0 && !injd && out_valid &&
          out_bin == 7'(inject)) begin
        fft_done = 1'b1;
        injd     = 1;
      end
      if (res_rd === 1'b1) begin
        if (issued - acc >= 4) credbad++;
        if (res_addr !== 7'(issued)) bad++;
        issued++;
      end
      if (out_valid === 1'b1) begin
        if (out_bin !== 7'(exp)) bad++;
        if (out_re !== ram_re[exp[6:0]]) bad++;
        if (out_im !== ram_im[exp[6:0]]) bad++;
        if (out_last !== (exp == 127)) bad++;
        if (out_ready) begin
          acc++;
          exp++;
        end
      end
      if (frame_done === 1'b1) done = 1;
      else begin
        tick();
        cyc++;
      end
    end
    fft_done  = 1'b0;
    check({tag, "_beats"}, exp, 128);
    check({tag, "_order"}, bad, 0);
    check({tag, "_credit"}, credbad, 0);
    check({tag, "_reads"}, issued, 128);
    check({tag, "_done"}, done, 1);
  endtask

  initial begin
    int nrd;
    int lastcnt;
    int bad;
    int guard;
    for (int k = 0; k < 128; k++) begin
      ram_re[k] = 8'(k);
      ram_im[k] = ~8'(k);
    end
    fft_done  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_rd", res_rd, 0);
    check("rst_addr", res_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    check("rst_re", out_re, 0);
    rst_n = 1'b1;
    tick();

    // 1: latency, full-rate frame, last and frame_done
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    check("t1_rd_c1", res_rd, 1);
    check("t1_addr_c1", res_addr, 0);
    check("t1_busy", busy, 1);
    tick();
    check("t1_nv_c2", out_valid, 0);
    tick();
    check("t1_v_c3", out_valid, 1);
    bad = 0;
    lastcnt = 0;
    for (int i = 0; i < 128; i++) begin
      if (out_valid !== 1'b1) bad++;
      if (out_bin !== 7'(i)) bad++;
      if (out_re !== 8'(i)) bad++;
      if (out_im !== ~8'(i)) bad++;
      if (out_last === 1'b1) lastcnt++;
      if ((out_last === 1'b1) != (i == 127)) bad++;
      tick();
    end
    check("t1_stream", bad, 0);
    check("t1_lastcnt", lastcnt, 1);
    check("t1_fdone", frame_done, 1);
    check("t1_idle", busy, 0);
    check("t1_empty", out_valid, 0);
    tick();
    check("t1_fdone_pulse", frame_done, 0);

    // 2: random back-pressure
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    stream("t2", 1, -1, 0);
    tick();

    // 3: stall with out_ready low
    out_ready = 1'b0;
    fft_done  = 1'b1;
    tick();
    fft_done = 1'b0;
    nrd = 0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (res_rd === 1'b1) nrd++;
      if (i > 3 && (out_bin !== 7'd0 || out_re !== 8'd0 ||
                    out_im !== 8'hff)) bad++;
      tick();
    end
    check("t3_reads", nrd, 4);
    check("t3_addr", res_addr, 3);
    check("t3_valid", out_valid, 1);
    check("t3_hold", bad, 0);
    stream("t3", 0, -1, 4);

    // 4: overrun mid-frame, then back-to-back restart
    tick();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    stream("t4a", 1, 60, 0);
    check("t4_ovr", overrun, 1);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    check("t4_restart_busy", busy, 1);
    check("t4_restart_rd", res_rd, 1);
    check("t4_restart_addr", res_addr, 0);
    stream("t4b", 0, -1, 0);
    check("t4_ovr_sticky", overrun, 1);

    // 5: reset mid-frame
    tick();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    guard = 0;
    while (!(out_valid && out_bin == 7'd40) && guard < 200) begin
      tick();
      guard++;
    end
    check("t5_reach40", guard < 200, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_valid", out_valid, 0);
    check("t5_bin", out_bin, 0);
    check("t5_re", out_re, 0);
    check("t5_busy", busy, 0);
    check("t5_ovr", overrun, 0);
    check("t5_rd", res_rd, 0);
    check("t5_addr", res_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    check("t5_rd_after", res_rd, 1);
    check("t5_addr_after", res_addr, 0);

`ifdef FFT_MAG_OUT_EN
    // 6: magnitude of corner bins
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ram_re[0] = 8'h80; ram_im[0] = 8'h80;
    ram_re[1] = 8'h7f; ram_im[1] = 8'hff;
    ram_re[2] = 8'h00; ram_im[2] = 8'h00;
    ram_re[3] = 8'hfb; ram_im[3] = 8'h03;
    out_ready = 1'b1;
    tick();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    tick();
    tick();
    check("t6_mag0", out_mag, 256);
    tick();
    check("t6_mag1", out_mag, 128);
    tick();
    check("t6_mag2", out_mag, 0);
    tick();
    check("t6_mag3", out_mag, 8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
